// File: rtl/hamming_encoder_tx.sv
// Hamming(15,11) encoder and serial transmitter; frames go out LSB first,
// optionally with one bit flipped on the line to exercise the receiver.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid to capture a word
// SHIFT | frame on the line, sh[idx] driven for BIT_CYCLES cycles per bit
module hamming_encoder_tx #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] in_data,
    input  logic [3:0]  in_err_pos,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] cw_out,
    output logic        cw_valid,
    output logic        tx_bit,
    output logic        tx_valid,
    output logic        tx_start,
    output logic        tx_done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(BIT_CYCLES - 1);

    state_t      state;
    logic [14:0] sh;
    logic [3:0]  idx;
    logic [7:0]  cnt;

    logic [14:0] cw;
    logic [14:0] err_mask;
    logic [14:0] sh_load;
    logic        bit_last;
    logic [3:0]  idx_nxt;
    logic [7:0]  cnt_nxt;

    always_comb begin
        cw        = '0;
        cw[2]     = in_data[0];
        cw[4]     = in_data[1];
        cw[5]     = in_data[2];
        cw[6]     = in_data[3];
        cw[14:8]  = in_data[10:4];
        cw[0]     = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14];
        cw[1]     = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
        cw[3]     = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
        cw[7]     = cw[8] ^ cw[9] ^ cw[10] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
        err_mask  = '0;
        if (in_err_pos != 4'd0) begin
            err_mask[in_err_pos - 4'd1] = 1'b1;
        end
        sh_load = cw ^ err_mask;
    end

    // Bit timer counts down; terminal count marks the last cycle of a bit.
    assign bit_last = (cnt == 8'd0);
    assign idx_nxt  = bit_last ? idx + 4'd1 : idx;
    assign cnt_nxt  = bit_last ? CNT_LOAD : cnt - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            cw_out   <= '0;
            cw_valid <= 1'b0;
            sh       <= '0;
            idx      <= '0;
            cnt      <= '0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_start <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            cw_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        cw_out   <= cw;
                        cw_valid <= 1'b1;
                        sh       <= sh_load;
                        idx      <= '0;
                        cnt      <= CNT_LOAD;
                        tx_bit   <= sh_load[0];
                        tx_valid <= 1'b1;
                        tx_start <= 1'b1;
                        tx_done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_last && idx == 4'd14) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        idx      <= '0;
                        cnt      <= '0;
                        tx_bit   <= 1'b0;
                        tx_valid <= 1'b0;
                        tx_start <= 1'b0;
                        tx_done  <= 1'b0;
                    end else begin
                        idx      <= idx_nxt;
                        cnt      <= cnt_nxt;
                        tx_bit   <= sh[idx_nxt];
                        tx_start <= (idx_nxt == 4'd0);
                        // Registered, so raised on the edge entering bit 14's last cycle.
                        tx_done  <= (idx_nxt == 4'd14) && (cnt_nxt == 8'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Bench for hamming_encoder_tx: one instance at BIT_CYCLES=1, one at 4,
// with a reference encoder/corrector model and an expected-frame queue.
module tb_hamming_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] a_data, b_data;
    logic [3:0]  a_err, b_err;
    logic        a_valid, b_valid;
    logic        a_ready, a_cwv, a_bit, a_txv, a_start, a_done;
    logic        b_ready, b_cwv, b_bit, b_txv, b_start, b_done;
    logic [14:0] a_cw, b_cw;

    hamming_encoder_tx #(.BIT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_err_pos(a_err),
        .in_valid(a_valid), .in_ready(a_ready), .cw_out(a_cw), .cw_valid(a_cwv),
        .tx_bit(a_bit), .tx_valid(a_txv), .tx_start(a_start), .tx_done(a_done)
    );

    hamming_encoder_tx #(.BIT_CYCLES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_err_pos(b_err),
        .in_valid(b_valid), .in_ready(b_ready), .cw_out(b_cw), .cw_valid(b_cwv),
        .tx_bit(b_bit), .tx_valid(b_txv), .tx_start(b_start), .tx_done(b_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          sel = 0;
    logic        m_ready, m_cwv, m_bit, m_txv, m_start, m_done;
    logic [14:0] m_cw;

    always_comb begin
        if (sel == 1) begin
            m_ready = b_ready; m_cwv = b_cwv; m_bit = b_bit; m_txv = b_txv;
            m_start = b_start; m_done = b_done; m_cw = b_cw;
        end else begin
            m_ready = a_ready; m_cwv = a_cwv; m_bit = a_bit; m_txv = a_txv;
            m_start = a_start; m_done = a_done; m_cw = a_cw;
        end
    end

    typedef struct {
        logic [10:0] data;
        logic [3:0]  err;
        logic [14:0] cw;
        logic [14:0] sh;
    } exp_t;

    typedef struct {
        bit          timeout;
        logic [14:0] cw;
        logic [14:0] stream;
        int          hold_err;
        int          start_err;
        int          done_err;
        int          valid_err;
        int          cwv_err;
        logic        end_ready;
        logic        end_txv;
        logic        end_bit;
    } obs_t;

    exp_t exp_q[$];

    // Reference model: data in non-power-of-two positions, parity over covered positions.
    function automatic logic [14:0] ref_enc(input logic [10:0] d);
        logic [14:0] c;
        logic        par;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int b = 1; b <= 8; b = b * 2) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if ((p & b) != 0 && p != b) par = par ^ c[p-1];
            end
            c[b-1] = par;
        end
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [14:0] c);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 15; i++) begin
            if (c[i]) s = s ^ 4'(i + 1);
        end
        return s;
    endfunction

    function automatic logic [10:0] decode(input logic [14:0] r);
        logic [14:0] c;
        logic [3:0]  s;
        logic [10:0] d;
        int          k;
        c = r;
        s = syndrome(c);
        if (s != 4'd0) c[s - 4'd1] = ~c[s - 4'd1];
        d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic drive(input int s, input logic v, input logic [10:0] d, input logic [3:0] e);
        if (s == 1) begin
            b_valid = v; b_data = d; b_err = e;
        end else begin
            a_valid = v; a_data = d; a_err = e;
        end
    endtask

    // Sends one word, pushes its expectation, and records what the line carried.
    task automatic xfer(input int s, input logic [10:0] d, input logic [3:0] e,
                        input bit chg, output obs_t o);
        exp_t x;
        int   n;
        int   j;
        o = '{default: 0};
        sel = s;
        n = (s == 1) ? 4 : 1;
        @(negedge clk);
        for (int w = 0; w < 200 && !m_ready; w++) @(negedge clk);
        if (!m_ready) begin
            o.timeout = 1'b1;
            return;
        end
        drive(s, 1'b1, d, e);
        x.data = d;
        x.err  = e;
        x.cw   = ref_enc(d);
        x.sh   = x.cw ^ ((e != 4'd0) ? (15'd1 << (e - 4'd1)) : 15'd0);
        exp_q.push_back(x);
        @(negedge clk);
        drive(s, 1'b0, d, e);
        o.cw = m_cw;
        for (int c = 0; c < 15 * n; c++) begin
            j = c / n;
            if (c % n == 0) o.stream[j] = m_bit;
            else if (m_bit !== o.stream[j]) o.hold_err++;
            if (m_start !== (j == 0)) o.start_err++;
            if (m_done !== (c == 15 * n - 1)) o.done_err++;
            if (m_txv !== 1'b1) o.valid_err++;
            if (m_cwv !== (c == 0)) o.cwv_err++;
            if (chg && c == 2) drive(s, 1'b0, 11'($urandom), 4'($urandom));
            @(negedge clk);
        end
        o.end_ready = m_ready;
        o.end_txv   = m_txv;
        o.end_bit   = m_bit;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_ready, a_cw, a_cwv, a_bit, a_txv, a_start, a_done} !== {1'b1, 15'd0, 5'd0}) begin
            n_errors++;
            $display("FAIL reset_a actual=%b expected=%b",
                     {a_ready, a_cw, a_cwv, a_bit, a_txv, a_start, a_done}, {1'b1, 15'd0, 5'd0});
        end
        n_checks++;
        if ({b_ready, b_cw, b_cwv, b_bit, b_txv, b_start, b_done} !== {1'b1, 15'd0, 5'd0}) begin
            n_errors++;
            $display("FAIL reset_b actual=%b expected=%b",
                     {b_ready, b_cw, b_cwv, b_bit, b_txv, b_start, b_done}, {1'b1, 15'd0, 5'd0});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_ready, a_txv, b_ready, b_txv} !== 4'b1010) begin
            n_errors++;
            $display("FAIL reset_release actual=%b expected=1010", {a_ready, a_txv, b_ready, b_txv});
        end
    endtask

    task automatic test_basic();
        obs_t o;
        xfer(0, 11'h001, 4'd0, 1'b0, o);
        n_checks++;
        if (o.timeout) begin
            n_errors++; $display("FAIL basic_timeout actual=1 expected=0"); return;
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (o.cw !== 15'h0007) begin n_errors++; $display("FAIL basic_cw actual=%h expected=0007", o.cw); end
        n_checks++;
        if (o.stream !== 15'h0007) begin n_errors++; $display("FAIL basic_stream actual=%h expected=0007", o.stream); end
        n_checks++;
        if (o.cwv_err !== 0) begin n_errors++; $display("FAIL basic_cw_valid bad_cycles=%0d expected=0", o.cwv_err); end
        n_checks++;
        if (o.start_err !== 0) begin n_errors++; $display("FAIL basic_tx_start bad_cycles=%0d expected=0", o.start_err); end
        n_checks++;
        if (o.done_err !== 0) begin n_errors++; $display("FAIL basic_tx_done bad_cycles=%0d expected=0", o.done_err); end
        n_checks++;
        if (o.valid_err !== 0) begin n_errors++; $display("FAIL basic_tx_valid bad_cycles=%0d expected=0", o.valid_err); end
        n_checks++;
        if ({o.end_ready, o.end_txv, o.end_bit} !== 3'b100) begin
            n_errors++;
            $display("FAIL basic_end ready/txv/bit actual=%b expected=100", {o.end_ready, o.end_txv, o.end_bit});
        end
    endtask

    task automatic test_patterns();
        logic [10:0] din [3];
        logic [14:0] cex [3];
        obs_t        o;
        din[0] = 11'h7FF; cex[0] = 15'h7FFF;
        din[1] = 11'h400; cex[1] = 15'h408B;
        din[2] = 11'h000; cex[2] = 15'h0000;
        for (int i = 0; i < 3; i++) begin
            xfer(0, din[i], 4'd0, 1'b0, o);
            n_checks++;
            if (o.timeout) begin
                n_errors++; $display("FAIL pattern_timeout idx=%0d", i); continue;
            end
            void'(exp_q.pop_front());
            n_checks++;
            if (o.cw !== cex[i]) begin n_errors++; $display("FAIL pattern_cw data=%h actual=%h expected=%h", din[i], o.cw, cex[i]); end
            n_checks++;
            if (o.stream !== cex[i]) begin n_errors++; $display("FAIL pattern_stream data=%h actual=%h expected=%h", din[i], o.stream, cex[i]); end
            n_checks++;
            if (o.valid_err !== 0) begin n_errors++; $display("FAIL pattern_tx_valid data=%h bad_cycles=%0d expected=0", din[i], o.valid_err); end
        end
    endtask

    task automatic test_err_inject();
        obs_t        o;
        exp_t        x;
        logic [10:0] d;
        xfer(0, 11'h001, 4'd3, 1'b0, o);
        n_checks++;
        if (o.timeout) begin
            n_errors++; $display("FAIL inject_timeout actual=1 expected=0"); return;
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (o.cw !== 15'h0007) begin n_errors++; $display("FAIL inject_cw actual=%h expected=0007", o.cw); end
        n_checks++;
        if (o.stream !== 15'h0003) begin n_errors++; $display("FAIL inject_stream actual=%h expected=0003", o.stream); end
        n_checks++;
        if (decode(o.stream) !== 11'h001) begin n_errors++; $display("FAIL inject_decode actual=%h expected=001", decode(o.stream)); end
        for (int e = 1; e <= 15; e++) begin
            d = 11'($urandom);
            xfer(0, d, 4'(e), 1'b0, o);
            n_checks++;
            if (o.timeout) begin
                n_errors++; $display("FAIL sweep_timeout err_pos=%0d", e); continue;
            end
            x = exp_q.pop_front();
            n_checks++;
            if (o.stream !== x.sh) begin n_errors++; $display("FAIL sweep_stream err_pos=%0d actual=%h expected=%h", e, o.stream, x.sh); end
            n_checks++;
            if (o.cw !== x.cw) begin n_errors++; $display("FAIL sweep_cw err_pos=%0d actual=%h expected=%h", e, o.cw, x.cw); end
            n_checks++;
            if (decode(o.stream) !== x.data) begin n_errors++; $display("FAIL sweep_decode err_pos=%0d actual=%h expected=%h", e, decode(o.stream), x.data); end
        end
    endtask

    task automatic test_slow_bits();
        obs_t o;
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            xfer(1, 11'($urandom), 4'($urandom), 1'b1, o);
            n_checks++;
            if (o.timeout) begin
                n_errors++; $display("FAIL slow_timeout idx=%0d", i); continue;
            end
            x = exp_q.pop_front();
            n_checks++;
            if (o.stream !== x.sh) begin n_errors++; $display("FAIL slow_stream actual=%h expected=%h", o.stream, x.sh); end
            n_checks++;
            if (o.cw !== x.cw) begin n_errors++; $display("FAIL slow_cw actual=%h expected=%h", o.cw, x.cw); end
            n_checks++;
            if (o.hold_err !== 0) begin n_errors++; $display("FAIL slow_hold bad_cycles=%0d expected=0", o.hold_err); end
            n_checks++;
            if (o.start_err !== 0) begin n_errors++; $display("FAIL slow_tx_start bad_cycles=%0d expected=0", o.start_err); end
            n_checks++;
            if (o.done_err !== 0) begin n_errors++; $display("FAIL slow_tx_done bad_cycles=%0d expected=0", o.done_err); end
            n_checks++;
            if (o.end_ready !== 1'b1) begin n_errors++; $display("FAIL slow_ready actual=%b expected=1", o.end_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] da, db;
        exp_t        x;
        int          pulses[$];
        sel = 1;
        da = 11'($urandom);
        db = da ^ 11'h555;
        @(negedge clk);
        for (int w = 0; w < 200 && !b_ready; w++) @(negedge clk);
        drive(1, 1'b1, da, 4'd0);
        x.data = da; x.err = 4'd0; x.cw = ref_enc(da); x.sh = x.cw;
        exp_q.push_back(x);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (b_cwv === 1'b1) begin
                pulses.push_back(cyc);
                x = exp_q.pop_front();
                n_checks++;
                if (b_cw !== x.cw) begin n_errors++; $display("FAIL b2b_cw pulse=%0d actual=%h expected=%h", pulses.size(), b_cw, x.cw); end
                drive(1, 1'b1, db, 4'd0);
                x.data = db; x.cw = ref_enc(db); x.sh = x.cw;
                exp_q.push_back(x);
            end
        end
        drive(1, 1'b0, db, 4'd0);
        exp_q.delete();
        n_checks++;
        if (pulses.size() !== 4) begin
            n_errors++; $display("FAIL b2b_count actual=%0d expected=4", pulses.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (pulses[i] - pulses[i-1] !== 61) begin
                    n_errors++; $display("FAIL b2b_spacing actual=%0d expected=61", pulses[i] - pulses[i-1]);
                end
            end
        end
        for (int w = 0; w < 200 && !b_ready; w++) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        exp_t x;
        sel = 0;
        @(negedge clk);
        for (int w = 0; w < 200 && !a_ready; w++) @(negedge clk);
        drive(0, 1'b1, 11'h5A5, 4'd0);
        @(negedge clk);
        drive(0, 1'b0, 11'h5A5, 4'd0);
        repeat (7) @(negedge clk);
        n_checks++;
        if (a_txv !== 1'b1) begin n_errors++; $display("FAIL midrst_inflight tx_valid actual=%b expected=1", a_txv); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, a_cw, a_cwv, a_bit, a_txv, a_start, a_done} !== {1'b1, 15'd0, 5'd0}) begin
            n_errors++;
            $display("FAIL midrst_async actual=%b expected=%b",
                     {a_ready, a_cw, a_cwv, a_bit, a_txv, a_start, a_done}, {1'b1, 15'd0, 5'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 11'h2C3, 4'd0, 1'b0, o);
        n_checks++;
        if (o.timeout) begin
            n_errors++; $display("FAIL midrst_timeout actual=1 expected=0"); return;
        end
        x = exp_q.pop_front();
        n_checks++;
        if (o.stream !== x.sh) begin n_errors++; $display("FAIL midrst_stream actual=%h expected=%h", o.stream, x.sh); end
        n_checks++;
        if (o.start_err !== 0) begin n_errors++; $display("FAIL midrst_tx_start bad_cycles=%0d expected=0", o.start_err); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t x;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(0, 11'($urandom), 4'($urandom), 1'b0, o);
            n_checks++;
            if (o.timeout) begin
                n_errors++; $display("FAIL rand_timeout word=%0d", i); continue;
            end
            x = exp_q.pop_front();
            n_checks++;
            if (o.cw !== x.cw) begin n_errors++; $display("FAIL rand_cw word=%0d actual=%h expected=%h", i, o.cw, x.cw); end
            n_checks++;
            if (syndrome(o.cw) !== 4'd0) begin n_errors++; $display("FAIL rand_syndrome word=%0d actual=%h expected=0", i, syndrome(o.cw)); end
            n_checks++;
            if (o.stream !== x.sh) begin n_errors++; $display("FAIL rand_stream word=%0d actual=%h expected=%h", i, o.stream, x.sh); end
            n_checks++;
            if (decode(o.stream) !== x.data) begin n_errors++; $display("FAIL rand_decode word=%0d actual=%h expected=%h", i, decode(o.stream), x.data); end
        end
    endtask

    initial begin
        a_data = '0; a_err = '0; a_valid = 1'b0;
        b_data = '0; b_err = '0; b_valid = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_err_inject();
        test_slow_bits();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
